snitch_icache_refill_arbiter: RTL and testbench

SNITCH_ICACHE_REFILL_ARBITER -- requirements
Module: snitch_icache_refill_arbiter

---
 rtl/snitch_icache_refill_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_snitch_icache_refill_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snitch_icache_refill_arbiter.sv
// snitch_icache_refill_arbiter
//   Arbitrates refill requests from NR_PORTS L0 caches onto one shared L1
//   refill port and routes responses back to the requester by id.
//   Demand fetches beat prefetches. Round-robin order applies within each class.
//   A grant that stalls on out_req_ready_i stays locked until its handshake.
// Ports
//   clk_i, rst_ni           clock, synchronous active-low reset
//   in_req_*                per-port request (addr, id = {port, is_prefetch}, valid/ready)
//   out_req_*               arbitrated request towards L1
//   out_rsp_*               shared response from L1
//   in_rsp_*                response broadcast to ports, per-port valid/ready
//   err_unknown_id_o        sticky flag: response to a bad port index or to an idle port
module snitch_icache_refill_arbiter #(
  parameter int unsigned NR_PORTS        = 4,
  parameter int unsigned FETCH_AW        = 32,
  parameter int unsigned LINE_WIDTH      = 128,
  parameter int unsigned MAX_OUTSTANDING = 2,
  localparam int unsigned ID_W           = $clog2(NR_PORTS) + 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NR_PORTS-1:0][FETCH_AW-1:0]  in_req_addr_i,
  input  logic [NR_PORTS-1:0][ID_W-1:0]      in_req_id_i,
  input  logic [NR_PORTS-1:0]                in_req_valid_i,
  output logic [NR_PORTS-1:0]                in_req_ready_o,
  output logic [FETCH_AW-1:0]                out_req_addr_o,
  output logic [ID_W-1:0]                    out_req_id_o,
  output logic                               out_req_valid_o,
  input  logic                               out_req_ready_i,
  input  logic [LINE_WIDTH-1:0]              out_rsp_data_i,
  input  logic                               out_rsp_error_i,
  input  logic [ID_W-1:0]                    out_rsp_id_i,
  input  logic                               out_rsp_valid_i,
  output logic                               out_rsp_ready_o,
  output logic [LINE_WIDTH-1:0]              in_rsp_data_o,
  output logic                               in_rsp_error_o,
  output logic [ID_W-1:0]                    in_rsp_id_o,
  output logic [NR_PORTS-1:0]                in_rsp_valid_o,
  input  logic [NR_PORTS-1:0]                in_rsp_ready_i,
  output logic                               err_unknown_id_o
);

  localparam int unsigned PW = $clog2(NR_PORTS);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {ST_FREE, ST_LOCKED} lock_state_t;

  lock_state_t                 state;
  logic [PW-1:0]               lock_idx;
  logic [PW-1:0]               rr_ptr;
  logic [NR_PORTS-1:0][CW-1:0] outstanding;

  logic [NR_PORTS-1:0] eligible;
  logic [PW-1:0]       cand;
  logic                dem_found, pf_found;
  logic [PW-1:0]       dem_idx, pf_idx;
  logic [PW-1:0]       grant;
  logic                grant_valid;
  logic                req_hs;

  logic [PW-1:0]       rsp_idx;
  logic                idx_ok;
  logic                rsp_hs;
  logic                rsp_to_idle;
  logic [NR_PORTS-1:0] inc, dec;

  // Eligibility depends only on registered counters, so responses never
  // reach the request path combinationally.
  always_comb begin
    for (int unsigned p = 0; p < NR_PORTS; p++) begin
      eligible[p] = in_req_valid_i[p] && (outstanding[p] < CW'(MAX_OUTSTANDING));
    end
  end

  // Two parallel round-robin searches starting at rr_ptr, one per class.
  always_comb begin
    dem_found = 1'b0;
    pf_found  = 1'b0;
    dem_idx   = '0;
    pf_idx    = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NR_PORTS; i++) begin
      cand = PW'((32'(rr_ptr) + i) % NR_PORTS);
      if (eligible[cand] && !in_req_id_i[cand][0] && !dem_found) begin
        dem_found = 1'b1;
        dem_idx   = cand;
      end
      if (eligible[cand] && in_req_id_i[cand][0] && !pf_found) begin
        pf_found = 1'b1;
        pf_idx   = cand;
      end
    end
  end

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    if (state == ST_LOCKED) begin
      grant       = lock_idx;
      grant_valid = in_req_valid_i[lock_idx];
    end else if (dem_found) begin
      grant       = dem_idx;
      grant_valid = 1'b1;
    end else if (pf_found) begin
      grant       = pf_idx;
      grant_valid = 1'b1;
    end
  end

  always_comb begin
    in_req_ready_o = '0;
    if (grant_valid) in_req_ready_o[grant] = out_req_ready_i;
  end

  assign out_req_valid_o = grant_valid;
  assign out_req_addr_o  = in_req_addr_i[grant];
  assign out_req_id_o    = in_req_id_i[grant];
  assign req_hs          = grant_valid && out_req_ready_i;

  // Response routing; an index beyond NR_PORTS is accepted and dropped.
  assign rsp_idx = out_rsp_id_i[ID_W-1:1];
  assign idx_ok  = 32'(rsp_idx) < NR_PORTS;

  always_comb begin
    in_rsp_valid_o  = '0;
    out_rsp_ready_o = 1'b1;
    rsp_to_idle     = 1'b0;
    if (idx_ok) begin
      in_rsp_valid_o[rsp_idx] = out_rsp_valid_i;
      out_rsp_ready_o         = in_rsp_ready_i[rsp_idx];
      rsp_to_idle             = (outstanding[rsp_idx] == '0);
    end
  end

  assign rsp_hs         = out_rsp_valid_i && out_rsp_ready_o;
  assign in_rsp_data_o  = out_rsp_data_i;
  assign in_rsp_error_o = out_rsp_error_i;
  assign in_rsp_id_o    = out_rsp_id_i;

  always_comb begin
    for (int unsigned p = 0; p < NR_PORTS; p++) begin
      inc[p] = req_hs && (grant == PW'(p));
      dec[p] = rsp_hs && idx_ok && (rsp_idx == PW'(p));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state            <= ST_FREE;
      lock_idx         <= '0;
      rr_ptr           <= '0;
      outstanding      <= '0;
      err_unknown_id_o <= 1'b0;
    end else begin
      case (state)
        ST_FREE: begin
          if (grant_valid && !out_req_ready_i) begin
            state    <= ST_LOCKED;
            lock_idx <= grant;
          end
        end
        ST_LOCKED: begin
          if (req_hs) state <= ST_FREE;
        end
        default: state <= ST_FREE;
      endcase

      if (req_hs) rr_ptr <= PW'((32'(grant) + 1) % NR_PORTS);

      for (int unsigned p = 0; p < NR_PORTS; p++) begin
        if (inc[p] && !dec[p]) begin
          outstanding[p] <= outstanding[p] + CW'(1);
        end else if (dec[p] && !inc[p] && (outstanding[p] != '0)) begin
          outstanding[p] <= outstanding[p] - CW'(1);
        end
      end

      if (rsp_hs && (!idx_ok || rsp_to_idle)) err_unknown_id_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_snitch_icache_refill_arbiter.sv
module tb_snitch_icache_refill_arbiter;

  localparam int NP = 4;
  localparam int AW = 32;
  localparam int LW = 128;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main DUT stimulus
  logic [NP-1:0]         vld = '0;
  logic [NP-1:0]         pf = '0;
  logic                  out_ready = 1'b1;
  logic [LW-1:0]         rsp_data = '0;
  logic                  rsp_err = 1'b0;
  logic [IW-1:0]         rsp_id = '0;
  logic                  rsp_valid = 1'b0;
  logic [NP-1:0]         rsp_ready = '1;
  logic [NP-1:0][AW-1:0] req_addr;
  logic [NP-1:0][IW-1:0] req_id;

  // main DUT outputs
  logic [NP-1:0] in_req_ready;
  logic [AW-1:0] out_addr;
  logic [IW-1:0] out_id;
  logic          out_valid;
  logic          out_rsp_ready;
  logic [LW-1:0] in_rsp_data;
  logic          in_rsp_error;
  logic [IW-1:0] in_rsp_id;
  logic [NP-1:0] in_rsp_valid;
  logic          err;

  function automatic logic [AW-1:0] addr_of(int p);
    return 32'h1000_0000 + 32'(p) * 32'h40;
  endfunction

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      req_addr[p] = addr_of(p);
      req_id[p]   = {2'(p), pf[p]};
    end
  end

  snitch_icache_refill_arbiter #(
    .NR_PORTS(NP), .FETCH_AW(AW), .LINE_WIDTH(LW), .MAX_OUTSTANDING(2)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_req_addr_i(req_addr), .in_req_id_i(req_id),
    .in_req_valid_i(vld), .in_req_ready_o(in_req_ready),
    .out_req_addr_o(out_addr), .out_req_id_o(out_id),
    .out_req_valid_o(out_valid), .out_req_ready_i(out_ready),
    .out_rsp_data_i(rsp_data), .out_rsp_error_i(rsp_err), .out_rsp_id_i(rsp_id),
    .out_rsp_valid_i(rsp_valid), .out_rsp_ready_o(out_rsp_ready),
    .in_rsp_data_o(in_rsp_data), .in_rsp_error_o(in_rsp_error), .in_rsp_id_o(in_rsp_id),
    .in_rsp_valid_o(in_rsp_valid), .in_rsp_ready_i(rsp_ready),
    .err_unknown_id_o(err)
  );

  // three-port instance: index 3 is representable but invalid
  logic [2:0][AW-1:0] req3_addr = '0;
  logic [2:0][IW-1:0] req3_id = '0;
  logic [2:0]         req3_valid = '0;
  logic [2:0]         req3_ready;
  logic [AW-1:0]      out3_addr;
  logic [IW-1:0]      out3_id;
  logic               out3_valid;
  logic [IW-1:0]      rsp3_id = '0;
  logic               rsp3_valid = 1'b0;
  logic [2:0]         rsp3_ready = '1;
  logic               out3_rsp_ready;
  logic [LW-1:0]      in3_rsp_data;
  logic               in3_rsp_error;
  logic [IW-1:0]      in3_rsp_id;
  logic [2:0]         in3_rsp_valid;
  logic               err3;

  snitch_icache_refill_arbiter #(
    .NR_PORTS(3), .FETCH_AW(AW), .LINE_WIDTH(LW), .MAX_OUTSTANDING(2)
  ) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .in_req_addr_i(req3_addr), .in_req_id_i(req3_id),
    .in_req_valid_i(req3_valid), .in_req_ready_o(req3_ready),
    .out_req_addr_o(out3_addr), .out_req_id_o(out3_id),
    .out_req_valid_o(out3_valid), .out_req_ready_i(1'b1),
    .out_rsp_data_i(rsp_data), .out_rsp_error_i(1'b0), .out_rsp_id_i(rsp3_id),
    .out_rsp_valid_i(rsp3_valid), .out_rsp_ready_o(out3_rsp_ready),
    .in_rsp_data_o(in3_rsp_data), .in_rsp_error_o(in3_rsp_error), .in_rsp_id_o(in3_rsp_id),
    .in_rsp_valid_o(in3_rsp_valid), .in_rsp_ready_i(rsp3_ready),
    .err_unknown_id_o(err3)
  );

  // scoreboard
  typedef enum {K_REQ, K_RSP, K_ERR, K_DROP, K_ERR3} kind_t;
  typedef struct {
    kind_t         kind;
    string         name;
    logic          v;
    int            g;
    logic [NP-1:0] vec;
  } exp_t;
  exp_t sb[$];

  int compared = 0;
  int mismatched = 0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic push(kind_t k, string n, logic v, int g, logic [NP-1:0] vec);
    exp_t e;
    e.kind = k; e.name = n; e.v = v; e.g = g; e.vec = vec;
    sb.push_back(e);
  endtask

  task automatic exp_req(string n, logic v, int g, logic [NP-1:0] rdy);
    push(K_REQ, n, v, g, rdy);
  endtask

  task automatic exp_rsp(string n, logic [NP-1:0] vv, logic rdy);
    push(K_RSP, n, rdy, 0, vv);
  endtask

  task automatic exp_err(string n, logic e);
    push(K_ERR, n, e, 0, '0);
  endtask

  // one cycle: compare queued expectations at the falling edge, then advance
  task automatic tick();
    @(negedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      case (e.kind)
        K_REQ: begin
          chk({e.name, ".valid"}, 128'(out_valid), 128'(e.v));
          if (e.v) begin
            chk({e.name, ".addr"}, 128'(out_addr), 128'(addr_of(e.g)));
            chk({e.name, ".id"}, 128'(out_id), 128'({2'(e.g), pf[e.g]}));
          end
          chk({e.name, ".in_req_ready"}, 128'(in_req_ready), 128'(e.vec));
        end
        K_RSP: begin
          chk({e.name, ".in_rsp_valid"}, 128'(in_rsp_valid), 128'(e.vec));
          chk({e.name, ".out_rsp_ready"}, 128'(out_rsp_ready), 128'(e.v));
          chk({e.name, ".data"}, in_rsp_data, rsp_data);
          chk({e.name, ".rsp_id"}, 128'(in_rsp_id), 128'(rsp_id));
        end
        K_ERR:  chk({e.name, ".err"}, 128'(err), 128'(e.v));
        K_DROP: begin
          chk({e.name, ".in_rsp_valid"}, 128'(in3_rsp_valid), 128'(e.vec[2:0]));
          chk({e.name, ".out_rsp_ready"}, 128'(out3_rsp_ready), 128'(e.v));
        end
        K_ERR3: chk({e.name, ".err"}, 128'(err3), 128'(e.v));
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    vld = '0; pf = '0; rsp_valid = 1'b0; rsp3_valid = 1'b0;
    out_ready = 1'b1; rsp_ready = '1; rsp3_ready = '1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [NP-1:0] vld;
    logic [NP-1:0] pf;
    logic          rdy;
    logic          exp_v;
    int            exp_g;
  } vec_t;
  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // single-cycle arbitration from the cleared state (rr_ptr=0, counters 0)
    tbl[0] = '{vld: 4'b0000, pf: 4'b0000, rdy: 1'b1, exp_v: 1'b0, exp_g: 0};
    tbl[1] = '{vld: 4'b0101, pf: 4'b0000, rdy: 1'b1, exp_v: 1'b1, exp_g: 0};
    tbl[2] = '{vld: 4'b1010, pf: 4'b0000, rdy: 1'b1, exp_v: 1'b1, exp_g: 1};
    tbl[3] = '{vld: 4'b1010, pf: 4'b0010, rdy: 1'b1, exp_v: 1'b1, exp_g: 3};
    tbl[4] = '{vld: 4'b1111, pf: 4'b1111, rdy: 1'b1, exp_v: 1'b1, exp_g: 0};
    tbl[5] = '{vld: 4'b1100, pf: 4'b0100, rdy: 1'b0, exp_v: 1'b1, exp_g: 3};
    tbl[6] = '{vld: 4'b0100, pf: 4'b0100, rdy: 1'b1, exp_v: 1'b1, exp_g: 2};
    tbl[7] = '{vld: 4'b0110, pf: 4'b0110, rdy: 1'b0, exp_v: 1'b1, exp_g: 1};

    do_reset();
    exp_req("reset_req", 1'b0, 0, 4'b0000);
    exp_rsp("reset_rsp", 4'b0000, 1'b1);
    exp_err("reset_err", 1'b0);
    tick();

    for (int i = 0; i < 8; i++) begin
      logic [NP-1:0] rv;
      do_reset();
      vld = tbl[i].vld; pf = tbl[i].pf; out_ready = tbl[i].rdy;
      rv = (tbl[i].exp_v && tbl[i].rdy) ? NP'(1 << tbl[i].exp_g) : '0;
      exp_req($sformatf("tbl%0d", i), tbl[i].exp_v, tbl[i].exp_g, rv);
      tick();
    end

    // A: round-robin across two demand ports, then pointer at 3
    do_reset();
    vld = 4'b0101;
    exp_req("A0", 1'b1, 0, 4'b0001); tick();
    vld = 4'b0100;
    exp_req("A1", 1'b1, 2, 4'b0100); tick();
    vld = 4'b1001;
    exp_req("A2_rr3", 1'b1, 3, 4'b1000); tick();

    // B: locked prefetch grant survives a new demand request
    do_reset();
    out_ready = 1'b0; vld = 4'b0010; pf = 4'b0010;
    exp_req("B0", 1'b1, 1, 4'b0000); tick();
    vld = 4'b0011;
    exp_req("B1_lock", 1'b1, 1, 4'b0000); tick();
    exp_req("B2_lock", 1'b1, 1, 4'b0000); tick();
    out_ready = 1'b1;
    exp_req("B3_hs", 1'b1, 1, 4'b0010); tick();
    vld = 4'b0001; pf = '0;
    exp_req("B4_next", 1'b1, 0, 4'b0001); tick();

    // C: outstanding limit and release by response
    do_reset();
    vld = 4'b0100;
    exp_req("C0", 1'b1, 2, 4'b0100); tick();
    exp_req("C1", 1'b1, 2, 4'b0100); tick();
    rsp_valid = 1'b1; rsp_id = 3'b100; rsp_data = {4{$urandom}};
    exp_req("C2_full", 1'b0, 0, 4'b0000);
    exp_rsp("C2_rsp", 4'b0100, 1'b1); tick();
    rsp_valid = 1'b0;
    exp_req("C3_again", 1'b1, 2, 4'b0100);
    exp_err("C3_err", 1'b0); tick();
    vld = '0;

    // D: backpressured routing, then response to an idle port
    do_reset();
    rsp_valid = 1'b1; rsp_id = 3'b101; rsp_ready = 4'b1011; rsp_data = {4{$urandom}};
    exp_rsp("D0_bp", 4'b0100, 1'b0);
    exp_req("D0_req", 1'b0, 0, 4'b0000); tick();
    rsp_id = 3'b000; rsp_ready = 4'b1111; rsp_data = {4{$urandom}};
    exp_rsp("D1_idle", 4'b0001, 1'b1); tick();
    rsp_valid = 1'b0;
    exp_err("D2_err", 1'b1);
    exp_rsp("D2_none", 4'b0000, 1'b1); tick();
    exp_err("D3_sticky", 1'b1); tick();

    // E: reset while a grant is locked and refills are outstanding
    do_reset();
    vld = 4'b0001;
    exp_req("E0", 1'b1, 0, 4'b0001); tick();
    vld = 4'b0010; out_ready = 1'b0;
    rsp_valid = 1'b1; rsp_id = 3'b110;
    exp_req("E1_lock", 1'b1, 1, 4'b0000); tick();
    rsp_valid = 1'b0;
    exp_err("E2_err", 1'b1);
    exp_req("E2_lock", 1'b1, 1, 4'b0000); tick();
    rst_n = 1'b0; vld = 4'b0011;
    tick();
    rst_n = 1'b1;
    exp_req("E3_cleared", 1'b1, 0, 4'b0000);
    exp_err("E3_err", 1'b0); tick();
    vld = '0; rsp_valid = 1'b1; rsp_id = 3'b000;
    exp_rsp("E4_rsp", 4'b0001, 1'b1); tick();
    rsp_valid = 1'b0;
    exp_err("E5_cnt0", 1'b1); tick();

    // F: three-port instance, invalid index dropped, valid one routed
    do_reset();
    rsp3_valid = 1'b1; rsp3_id = 3'b100; rsp3_ready = 3'b011;
    push(K_DROP, "F0_route", 1'b0, 0, 4'b0100);
    push(K_ERR3, "F0_err", 1'b0, 0, '0); tick();
    rsp3_id = 3'b110;
    push(K_DROP, "F1_drop", 1'b1, 0, 4'b0000); tick();
    rsp3_valid = 1'b0;
    push(K_ERR3, "F2_err", 1'b1, 0, '0); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
